// File: rtl/tc_pkg.sv
// Shared types and helpers for the operand two's-complement stage.
package tc_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHU  = 2'b10,
        OP_MULHSU = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        PREC_8  = 2'b00,
        PREC_16 = 2'b01,
        PREC_32 = 2'b10,
        PREC_64 = 2'b11
    } precision_e;

    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // A is signed for every opcode except mulhu; B only for mul and mulh.
    function automatic logic is_signed(opcode_e opcode, logic operand_sel);
        if (operand_sel == SEL_A) begin
            return opcode != OP_MULHU;
        end
        return (opcode == OP_MUL) || (opcode == OP_MULH);
    endfunction

    // 64-bit precision on a 32-bit datapath falls back to byte elements.
    function automatic int unsigned lanes_per_elem(precision_e prec, int unsigned data_w);
        case (prec)
            PREC_8:  return 1;
            PREC_16: return 2;
            PREC_32: return 4;
            default: return (data_w == 64) ? 8 : 1;
        endcase
    endfunction

endpackage

// File: rtl/tc_seg_negate.sv
// Segmented conditional two's-complement negate of one packed operand.
module tc_seg_negate
    import tc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0]   data,
    input  logic [1:0]          precision,
    input  logic                sign_en,
    output logic [DATA_W-1:0]   mag,
    output logic [DATA_W/8-1:0] mask
);

    localparam int unsigned NB = DATA_W / 8;

    int unsigned   lpe;
    int unsigned   top;
    logic [7:0]    top_byte;
    logic          neg;
    logic          first;
    logic [NB:0]   carry;

    // Carry is re-seeded at the first lane of every element so it never crosses a boundary.
    always_comb begin
        lpe      = lanes_per_elem(precision_e'(precision), DATA_W);
        top      = 0;
        top_byte = '0;
        neg      = 1'b0;
        first    = 1'b0;
        carry    = '0;
        mag      = '0;
        mask     = '0;
        for (int unsigned l = 0; l < NB; l++) begin
            top      = l | (lpe - 1);
            top_byte = data[top*8 +: 8];
            neg      = sign_en && top_byte[7];
            first    = (l & (lpe - 1)) == 0;
            {carry[l+1], mag[l*8 +: 8]} = {1'b0, data[l*8 +: 8] ^ {8{neg}}}
                                        + {8'd0, first ? neg : carry[l]};
            mask[l]  = neg;
        end
    end

endmodule

// File: rtl/operand_tc_stage.sv
// Operand sign-magnitude stage: per-element magnitudes and negate flags, registered with a skid buffer.
module operand_tc_stage
    import tc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          opcode,
    input  logic [1:0]          precision,
    input  logic [DATA_W-1:0]   operand_a,
    input  logic [DATA_W-1:0]   operand_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   mag_a,
    output logic [DATA_W-1:0]   mag_b,
    output logic [DATA_W/8-1:0] neg_a,
    output logic [DATA_W/8-1:0] neg_b,
    output logic [DATA_W/8-1:0] neg_res,
    output logic [1:0]          out_prec,
    output logic [1:0]          out_opcode
);

    localparam int unsigned NB = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] mag_a;
        logic [DATA_W-1:0] mag_b;
        logic [NB-1:0]     neg_a;
        logic [NB-1:0]     neg_b;
        logic [NB-1:0]     neg_res;
        logic [1:0]        prec;
        logic [1:0]        opcode;
    } beat_t;

    // S_SKID means the output register and the skid buffer are both occupied.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_FULL  = 2'b01,
        S_SKID  = 2'b10
    } state_e;

    state_e            state;
    state_e            state_next;
    beat_t             beat_in;
    beat_t             out_reg;
    beat_t             skid_reg;
    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-1:0] mag_a_c;
    logic [DATA_W-1:0] mag_b_c;
    logic [NB-1:0]     neg_a_c;
    logic [NB-1:0]     neg_b_c;
    logic              in_acc;
    logic              out_acc;

    assign sign_a  = is_signed(opcode_e'(opcode), SEL_A);
    assign sign_b  = is_signed(opcode_e'(opcode), SEL_B);
    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;

    tc_seg_negate #(.DATA_W(DATA_W)) u_neg_a (
        .data      (operand_a),
        .precision (precision),
        .sign_en   (sign_a),
        .mag       (mag_a_c),
        .mask      (neg_a_c)
    );

    tc_seg_negate #(.DATA_W(DATA_W)) u_neg_b (
        .data      (operand_b),
        .precision (precision),
        .sign_en   (sign_b),
        .mag       (mag_b_c),
        .mask      (neg_b_c)
    );

    always_comb begin
        beat_in         = '0;
        beat_in.mag_a   = mag_a_c;
        beat_in.mag_b   = mag_b_c;
        beat_in.neg_a   = neg_a_c;
        beat_in.neg_b   = neg_b_c;
        beat_in.neg_res = neg_a_c ^ neg_b_c;
        beat_in.prec    = precision;
        beat_in.opcode  = opcode;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (in_acc) state_next = S_FULL;
            S_FULL: begin
                if (in_acc && !out_acc)      state_next = S_SKID;
                else if (out_acc && !in_acc) state_next = S_EMPTY;
            end
            S_SKID:  if (out_acc) state_next = S_FULL;
            default: state_next = S_EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= state_next != S_EMPTY;
            in_ready  <= state_next != S_SKID;
            case (state)
                S_EMPTY: if (in_acc) out_reg <= beat_in;
                S_FULL: begin
                    if (in_acc && out_acc) out_reg  <= beat_in;
                    else if (in_acc)       skid_reg <= beat_in;
                end
                S_SKID:  if (out_acc) out_reg <= skid_reg;
                default: ;
            endcase
        end
    end

    assign mag_a      = out_reg.mag_a;
    assign mag_b      = out_reg.mag_b;
    assign neg_a      = out_reg.neg_a;
    assign neg_b      = out_reg.neg_b;
    assign neg_res    = out_reg.neg_res;
    assign out_prec   = out_reg.prec;
    assign out_opcode = out_reg.opcode;

endmodule

// File: tb/tb_operand_tc_stage.sv
// Scoreboard bench for operand_tc_stage at DATA_W=32 and DATA_W=64.
`timescale 1ns/1ps
module tb_operand_tc_stage;

    typedef struct packed {
        logic [63:0] mag_a;
        logic [63:0] mag_b;
        logic [7:0]  neg_a;
        logic [7:0]  neg_b;
        logic [7:0]  neg_res;
        logic [1:0]  prec;
        logic [1:0]  op;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb32[$];
    exp_t sb64[$];
    logic rand_rdy = 1'b0;

    logic        iv32 = 1'b0, or32 = 1'b1, ir32, ov32;
    logic [1:0]  op32 = '0, pr32 = '0, oprec32, oop32;
    logic [31:0] a32 = '0, b32 = '0, ma32, mb32;
    logic [3:0]  na32, nb32, nr32;

    logic        iv64 = 1'b0, or64 = 1'b1, ir64, ov64;
    logic [1:0]  op64 = '0, pr64 = '0, oprec64, oop64;
    logic [63:0] a64 = '0, b64 = '0, ma64, mb64;
    logic [7:0]  na64, nb64, nr64;

    operand_tc_stage #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .opcode(op32),
        .precision(pr32), .operand_a(a32), .operand_b(b32), .out_valid(ov32),
        .out_ready(or32), .mag_a(ma32), .mag_b(mb32), .neg_a(na32), .neg_b(nb32),
        .neg_res(nr32), .out_prec(oprec32), .out_opcode(oop32)
    );

    operand_tc_stage #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .opcode(op64),
        .precision(pr64), .operand_a(a64), .operand_b(b64), .out_valid(ov64),
        .out_ready(or64), .mag_a(ma64), .mag_b(mb64), .neg_a(na64), .neg_b(nb64),
        .neg_res(nr64), .out_prec(oprec64), .out_opcode(oop64)
    );

    // Reference: split into elements as integers, negate arithmetically when signed and negative.
    function automatic exp_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] op, input logic [1:0] pr);
        exp_t            r   = '0;
        int unsigned     ew  = (pr == 2'd3) ? ((w == 64) ? 64 : 8) : (8 << pr);
        longint unsigned msk = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        bit              sa  = (op != 2'b10);
        bit              sb  = (op == 2'b00) || (op == 2'b01);
        for (int unsigned e = 0; e < w / ew; e++) begin
            longint unsigned ea = (a >> (e * ew)) & msk;
            longint unsigned eb = (b >> (e * ew)) & msk;
            bit na = sa && (((ea >> (ew - 1)) & 64'd1) != 0);
            bit nb = sb && (((eb >> (ew - 1)) & 64'd1) != 0);
            if (na) ea = (64'd0 - ea) & msk;
            if (nb) eb = (64'd0 - eb) & msk;
            r.mag_a |= ea << (e * ew);
            r.mag_b |= eb << (e * ew);
            for (int unsigned k = 0; k < ew / 8; k++) begin
                r.neg_a[e * (ew / 8) + k] = na;
                r.neg_b[e * (ew / 8) + k] = nb;
            end
        end
        r.neg_res = r.neg_a ^ r.neg_b;
        r.prec    = pr;
        r.op      = op;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_beat(input string tag, input exp_t act, input exp_t exp);
        check({tag, ".mag_a"},   act.mag_a,   exp.mag_a);
        check({tag, ".mag_b"},   act.mag_b,   exp.mag_b);
        check({tag, ".neg_a"},   act.neg_a,   exp.neg_a);
        check({tag, ".neg_b"},   act.neg_b,   exp.neg_b);
        check({tag, ".neg_res"}, act.neg_res, exp.neg_res);
        check({tag, ".prec"},    act.prec,    exp.prec);
        check({tag, ".op"},      act.op,      exp.op);
    endtask

    // Expected values enter the scoreboard when the input handshake is seen.
    always @(negedge clk) begin
        if (!rst && iv32 && ir32) sb32.push_back(model(32, 64'(a32), 64'(b32), op32, pr32));
        if (!rst && iv64 && ir64) sb64.push_back(model(64, a64, b64, op64, pr64));
    end

    exp_t prev32, act32;
    logic stall32 = 1'b0, irlow32 = 1'b0;
    always @(negedge clk) begin
        act32 = '{64'(ma32), 64'(mb32), 8'(na32), 8'(nb32), 8'(nr32), oprec32, oop32};
        if (rst) begin
            stall32 = 1'b0;
            irlow32 = 1'b0;
        end else begin
            if (stall32) begin
                check("stall32.out_valid", 64'(ov32), 64'd1);
                compare_beat("stable32", act32, prev32);
            end
            if (or32 && irlow32) check("in_ready_gap32", 64'(ir32), 64'd1);
            if (ov32 && or32) begin
                if (sb32.size() == 0) check("unexpected32", 64'(ov32), 64'd0);
                else compare_beat("data32", act32, sb32.pop_front());
            end
            stall32 = ov32 && !or32;
            irlow32 = !ir32 && or32;
            prev32  = act32;
        end
    end

    exp_t prev64, act64;
    logic stall64 = 1'b0, irlow64 = 1'b0;
    always @(negedge clk) begin
        act64 = '{ma64, mb64, na64, nb64, nr64, oprec64, oop64};
        if (rst) begin
            stall64 = 1'b0;
            irlow64 = 1'b0;
        end else begin
            if (stall64) begin
                check("stall64.out_valid", 64'(ov64), 64'd1);
                compare_beat("stable64", act64, prev64);
            end
            if (or64 && irlow64) check("in_ready_gap64", 64'(ir64), 64'd1);
            if (ov64 && or64) begin
                if (sb64.size() == 0) check("unexpected64", 64'(ov64), 64'd0);
                else compare_beat("data64", act64, sb64.pop_front());
            end
            stall64 = ov64 && !or64;
            irlow64 = !ir64 && or64;
            prev64  = act64;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            or32 = ($urandom_range(0, 3) != 0);
            or64 = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [1:0] pr);
        int unsigned t = 0;
        iv32 = 1'b1; a32 = a; b32 = b; op32 = op; pr32 = pr;
        @(negedge clk);
        while (!ir32 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send32_timeout", 64'(ir32), 64'd1);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic [1:0] pr);
        int unsigned t = 0;
        iv64 = 1'b1; a64 = a; b64 = b; op64 = op; pr64 = pr;
        @(negedge clk);
        while (!ir64 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send64_timeout", 64'(ir64), 64'd1);
        @(posedge clk);
        #1;
        iv64 = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((sb32.size() != 0 || sb64.size() != 0 || ov32 || ov64) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) check("drain_timeout", 64'(sb32.size() + sb64.size()), 64'd0);
    endtask

    initial begin
        #1;
        check("rst.out_valid32", 64'(ov32), 64'd0);
        check("rst.in_ready32",  64'(ir32), 64'd0);
        check("rst.mag_a32",     64'(ma32), 64'd0);
        check("rst.neg_res32",   64'(nr32), 64'd0);
        check("rst.out_valid64", 64'(ov64), 64'd0);
        check("rst.mag_b64",     mb64,      64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("pre_edge.in_ready32", 64'(ir32), 64'd0);
        @(posedge clk);
        #1;
        check("post_rst.in_ready32", 64'(ir32), 64'd1);
        check("post_rst.in_ready64", 64'(ir64), 64'd1);

        send32(32'h80FF_017F, 32'h0101_0101, 2'b00, 2'b00);
        check("s1.latency_valid", 64'(ov32), 64'd1);
        check("s1.mag_a",   64'(ma32), 64'h8001_017F);
        check("s1.neg_a",   64'(na32), 64'b1100);
        check("s1.neg_b",   64'(nb32), 64'b0000);
        check("s1.neg_res", 64'(nr32), 64'b1100);
        drain();

        send32(32'hFFFE_0002, 32'h8000_FFFF, 2'b11, 2'b01);
        check("s2.mag_a", 64'(ma32), 64'h0002_0002);
        check("s2.mag_b", 64'(mb32), 64'h8000_FFFF);
        check("s2.neg_a", 64'(na32), 64'b1100);
        check("s2.neg_b", 64'(nb32), 64'b0000);
        drain();

        send32(32'hFFFF_FFFF, 32'h1234_5678, 2'b10, 2'b10);
        check("s3.mag_a", 64'(ma32), 64'hFFFF_FFFF);
        check("s3.neg_a", 64'(na32), 64'b0000);
        drain();

        send64(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b01, 2'b11);
        check("s4.mag_a",   ma64,       64'h1);
        check("s4.mag_b",   mb64,       64'h8000_0000_0000_0000);
        check("s4.neg_a",   64'(na64),  64'hFF);
        check("s4.neg_res", 64'(nr64),  64'h00);
        drain();

        rand_rdy = 1'b1;
        repeat (1000) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send32($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        repeat (300) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send64({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        or32 = 1'b1;
        or64 = 1'b1;
        drain();

        // Fill output register and skid, then reset mid-transfer.
        or32 = 1'b0;
        send32(32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00);
        send32(32'h8383_8383, 32'h4444_4444, 2'b00, 2'b01);
        check("skid.in_ready_low", 64'(ir32), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.out_valid", 64'(ov32), 64'd0);
        check("midrst.mag_a",     64'(ma32), 64'd0);
        sb32.delete();
        sb64.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        or32 = 1'b1;
        @(posedge clk);
        #1;
        send32(32'hC0FF_EE00, 32'h0BAD_F00D, 2'b01, 2'b10);
        check("postrst.first_mag_a", 64'(ma32), 64'h3F00_1200);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("postrst.no_stale", 64'(ov32), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_tc_stage.md
OPERAND_TC_STAGE -- requirements
Module: operand_tc_stage

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 32, operand width in bits; legal values 32 or 64.
- NB, DATA_W/8, byte-lane count; derived, not overridable.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage can accept input.
- opcode  in  2  00 mul, 01 mulh, 10 mulhu, 11 mulhsu.
- precision  in  2  00 8-bit, 01 16-bit, 10 32-bit, 11 64-bit when DATA_W=64, else 8-bit.
- operand_a  in  DATA_W  packed element vector A.
- operand_b  in  DATA_W  packed element vector B.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts output.
- mag_a  out  DATA_W  per-element magnitude of A.
- mag_b  out  DATA_W  per-element magnitude of B.
- neg_a  out  NB  per-byte-lane flag: A element was negated.
- neg_b  out  NB  per-byte-lane flag: B element was negated.
- neg_res  out  NB  per-byte-lane flag: product must be negated.
- out_prec  out  2  precision carried with the data.
- out_opcode  out  2  opcode carried with the data.

Function
REQ-003 Element size SHALL be set by precision; elements are contiguous, aligned, and LSB-first.
REQ-004 A SHALL be treated as signed for opcode 00, 01 and 11; B SHALL be treated as signed for opcode 00 and 01.
REQ-005 An element SHALL be negated iff its operand is signed and the element MSB is 1; otherwise it passes unchanged.
REQ-006 Negation SHALL be two's complement (invert, +1), with the carry confined to the element; no carry crosses an element boundary.
REQ-007 The most-negative element (e.g. 0x80 at 8-bit) SHALL yield the same bit pattern (0x80), read as unsigned magnitude; there is no overflow flag.
REQ-008 The neg_a/neg_b bits SHALL be replicated across every byte lane of an element.
REQ-009 neg_res SHALL equal neg_a XOR neg_b per lane.
REQ-010 A transfer SHALL occur on a clk edge where valid and ready are both high, on each side independently.
REQ-011 Latency SHALL be 1 cycle: an input accepted at edge N appears with out_valid=1 after edge N when the output register is free.
REQ-012 The datapath SHALL be an output register plus a one-entry skid buffer. in_ready SHALL be !skid_full; it depends on registered state only, with no combinational path from out_ready.
REQ-013 Output register states and transitions:
- EMPTY -> FULL on input accept.
- FULL -> EMPTY on output accept with no input.
- FULL -> FULL on simultaneous output accept and input accept; the new data loads the output register.
REQ-014 If an input is accepted while output is stalled (out_valid=1, out_ready=0), the data SHALL go to the skid buffer and in_ready SHALL drop the next cycle.
REQ-015 On output accept with skid full, skid content SHALL move to the output register and in_ready SHALL rise the next cycle.
REQ-016 Ordering SHALL be strict FIFO, and no transaction SHALL be dropped or duplicated.
REQ-017 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-018 Inputs SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-019 While rst=1, the following SHALL be cleared asynchronously: out_valid=0, skid_full=0, in_ready=0; mag_a, mag_b, neg_a, neg_b, neg_res, out_prec and out_opcode all zero.
REQ-020 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-021 Reset mid-transfer SHALL discard both the output register and skid content; no transaction is emitted for them after reset.

Structure
REQ-022 Package tc_pkg SHALL hold the opcode_e and precision_e enums, DATA_W_DEFAULT, and the function is_signed(opcode, operand_sel).
REQ-023 Sub-module tc_seg_negate SHALL implement the segmented conditional negate for one operand. It is instantiated twice (A, B), and outputs magnitude plus the NB-bit negate mask.

Verification
REQ-024 Scenarios:
- DATA_W=32, prec 00, op 00, A=0x80FF017F, B=0x01010101 -> mag_a=0x8001017F, neg_a=1100, neg_b=0000, neg_res=1100, 1-cycle latency.
- prec 01, op 11, A=0xFFFE0002, B=0x8000FFFF -> mag_a=0x00020002, mag_b=0x8000FFFF, neg_a=1100, neg_b=0000.
- prec 10, op 10, A=0xFFFFFFFF -> mag_a=0xFFFFFFFF, neg_a=0000 (unsigned passthrough).
- DATA_W=64, prec 11, op 01, A=0xFFFFFFFFFFFFFFFF, B=0x8000000000000000 -> mag_a=0x1, mag_b unchanged, neg_res=all 0s (1 XOR 1).
- Random in_valid/out_ready toggling, 1000 transactions -> scoreboard in-order match, outputs stable under stall, in_ready never low for 2+ consecutive cycles while out_ready=1.
- rst asserted with both registers full -> out_valid=0 immediately; first post-reset output is the first post-reset input.
